// File: rtl/matrix_entry_if.sv
// Bus bundle for matrix_entry: control/button inputs and the packed matrix outputs.
interface matrix_entry_if #(
  parameter int N_ELEM = 25,
  parameter int ELEM_W = 8
);
  logic                     start;
  logic [ELEM_W-1:0]        sw_value;
  logic                     btn_enter_n;
  logic                     btn_undo_n;
  logic [N_ELEM*ELEM_W-1:0] matrix_in;
  logic [4:0]               index;
  logic                     busy;
  logic                     matrix_valid;
  logic                     done;

  modport master (
    output start, sw_value, btn_enter_n, btn_undo_n,
    input  matrix_in, index, busy, matrix_valid, done
  );

  modport slave (
    input  start, sw_value, btn_enter_n, btn_undo_n,
    output matrix_in, index, busy, matrix_valid, done
  );
endinterface

// File: rtl/matrix_entry.sv
// Debounced button-driven writer for a packed signed matrix with undo/restart.
// Optional MATRIX_ENTRY_CLAMP_EN saturates stored values to [-99, +99].
module matrix_entry #(
  parameter int N_ELEM          = 25,
  parameter int ELEM_W          = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_entry_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

  // Bit 0 is ENTER, bit 1 is UNDO; all levels active-low, reset to released.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, deb, ev;
  logic [CW-1:0] cnt [2];

  assign raw = {bus.btn_undo_n, bus.btn_enter_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      ev    <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
            ev[i]  <= ~sync2[i];
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic [ELEM_W-1:0] store_val;

`ifdef MATRIX_ENTRY_CLAMP_EN
  localparam logic signed [ELEM_W-1:0] MAX_V = ELEM_W'(99);
  localparam logic signed [ELEM_W-1:0] MIN_V = ELEM_W'(-99);

  always_comb begin
    store_val = bus.sw_value;
    if ($signed(bus.sw_value) > MAX_V)      store_val = MAX_V;
    else if ($signed(bus.sw_value) < MIN_V) store_val = MIN_V;
  end
`else
  assign store_val = bus.sw_value;
`endif

  state_t                   state_q, state_d;
  logic [4:0]               index_q, index_d;
  logic [N_ELEM*ELEM_W-1:0] matrix_q, matrix_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      matrix_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      matrix_q <= matrix_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // start wins over any button event; simultaneous ENTER+UNDO cancel out.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    matrix_d = matrix_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    if (bus.start) begin
      state_d  = ENTRY;
      index_d  = '0;
      matrix_d = '0;
      valid_d  = 1'b0;
    end else if (state_q == ENTRY && (ev[0] ^ ev[1])) begin
      if (ev[0]) begin
        matrix_d[index_q*ELEM_W +: ELEM_W] = store_val;
        if (index_q == 5'(N_ELEM - 1)) begin
          done_d  = 1'b1;
          valid_d = 1'b1;
          index_d = '0;
          state_d = DONE;
        end else begin
          index_d = index_q + 5'd1;
        end
      end else if (index_q != '0) begin
        index_d = index_q - 5'd1;
      end
    end
  end

  assign bus.matrix_in    = matrix_q;
  assign bus.index        = index_q;
  assign bus.busy         = (state_q == ENTRY);
  assign bus.matrix_valid = valid_q;
  assign bus.done         = done_q;
endmodule
